// File: rtl/sprite_renderer_if.sv
// ---------------------------------------------------------------------------
// sprite_renderer_if
//   Bus between the sprite renderer and its two external synchronous ROMs.
//   Both ROMs return data one clock after the address is presented.
//   master : renderer side (drives addresses, receives data)
//   slave  : ROM side      (receives addresses, drives data)
// Signals
//   map_addr  MAP_AW    colour-map ROM address
//   map_data  PAL_BITS  colour-map ROM data (palette index)
//   pal_addr  PAL_BITS  palette ROM address
//   pal_data  24        palette ROM RGB
// ---------------------------------------------------------------------------
interface sprite_renderer_if #(
    parameter int MAP_AW   = 14,
    parameter int PAL_BITS = 4
);
    logic [MAP_AW-1:0]   map_addr;
    logic [PAL_BITS-1:0] map_data;
    logic [PAL_BITS-1:0] pal_addr;
    logic [23:0]         pal_data;

    modport master (
        output map_addr,
        output pal_addr,
        input  map_data,
        input  pal_data
    );

    modport slave (
        input  map_addr,
        input  pal_addr,
        output map_data,
        output pal_data
    );
endinterface

// File: rtl/sprite_renderer.sv
// ---------------------------------------------------------------------------
// sprite_renderer
//   Multi-frame sprite pixel generator. For every pixel position it looks up a
//   palette index in the colour-map ROM, then the RGB value in the palette ROM,
//   and emits the pixel with a valid flag for the video mixer. Fixed 5-cycle
//   latency from hcount/vcount to pixel_o/pixel_vld_o, no stalls.
//   Position, frame, mirror and enable are shadowed once per video frame.
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hcount_i     current pixel column (11 bit)
//   vcount_i     current pixel row (10 bit)
//   blank_i      blanking interval, suppresses drawing
//   enable_i     sprite shown (takes effect at frame start)
//   x_i, y_i     sprite top-left corner (16 bit each)
//   frame_sel_i  animation frame index, clamped to NUM_FRAMES-1
//   mirror_i     horizontal flip
//   rom          ROM bus (master side)
//   pixel_o      RGB, zero when not valid
//   pixel_vld_o  opaque sprite pixel this cycle
// ---------------------------------------------------------------------------
module sprite_renderer #(
    parameter int SPRITE_W   = 64,
    parameter int SPRITE_H   = 64,
    parameter int NUM_FRAMES = 3,
    parameter int PAL_BITS   = 4,
    parameter int MAP_AW     = 14,
    parameter int TRANSP_IDX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        blank_i,
    input  logic        enable_i,
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [7:0]  frame_sel_i,
    input  logic        mirror_i,
    sprite_renderer_if.master rom,
    output logic [23:0] pixel_o,
    output logic        pixel_vld_o
);
    localparam int unsigned FRAME_SZ = SPRITE_W * SPRITE_H;
    localparam logic signed [16:0] W_S = 17'(SPRITE_W);
    localparam logic signed [16:0] H_S = 17'(SPRITE_H);

    // Shadow registers, loaded only at the first pixel of a video frame
    logic [15:0] xs_q, xs_d;
    logic [15:0] ys_q, ys_d;
    logic [7:0]  frame_q, frame_d;
    logic        mirror_q, mirror_d;
    logic        en_q, en_d;

    logic              frame_start;
    logic signed [16:0] dx, dy;
    logic              in_box;
    logic [15:0]       col;
    logic [MAP_AW-1:0] addr;

    logic [MAP_AW-1:0]   map_addr_q, map_addr_d;
    logic [PAL_BITS-1:0] pal_addr_q;
    logic                v1_q, v2_q, v3_q, v4_q;
    logic [23:0]         pixel_q;
    logic                pixel_vld_q;

    assign frame_start = (hcount_i == 11'd0) && (vcount_i == 10'd0);

    always_comb begin
        xs_d     = xs_q;
        ys_d     = ys_q;
        frame_d  = frame_q;
        mirror_d = mirror_q;
        en_d     = en_q;
        if (frame_start) begin
            xs_d     = x_i;
            ys_d     = y_i;
            frame_d  = (frame_sel_i >= 8'(NUM_FRAMES)) ? 8'(NUM_FRAMES - 1) : frame_sel_i;
            mirror_d = mirror_i;
            en_d     = enable_i;
        end
    end

    // Stage 0: 17-bit signed offsets. The extra bit keeps large x/y from
    // wrapping into range, so a sprite placed beyond column 2047 is never drawn.
    assign dx = $signed({6'd0, hcount_i}) - $signed({1'b0, xs_q});
    assign dy = $signed({7'd0, vcount_i}) - $signed({1'b0, ys_q});

    assign in_box = en_q & ~blank_i
                  & ~dx[16] & (dx < W_S)
                  & ~dy[16] & (dy < H_S);

    // Only meaningful when in_box, where dx/dy are small and non-negative
    assign col  = mirror_q ? (16'(SPRITE_W - 1) - dx[15:0]) : dx[15:0];
    assign addr = MAP_AW'(32'(frame_q) * FRAME_SZ
                        + 32'(dy[15:0]) * 32'(SPRITE_W)
                        + 32'(col));

    // Outside the box the address is held to avoid needless ROM toggling
    assign map_addr_d = in_box ? addr : map_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q        <= '0;
            ys_q        <= '0;
            frame_q     <= '0;
            mirror_q    <= 1'b0;
            en_q        <= 1'b0;
            map_addr_q  <= '0;
            pal_addr_q  <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            pixel_q     <= '0;
            pixel_vld_q <= 1'b0;
        end else begin
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            frame_q     <= frame_d;
            mirror_q    <= mirror_d;
            en_q        <= en_d;
            // t+1: map ROM address
            map_addr_q  <= map_addr_d;
            v1_q        <= in_box;
            // t+2: map ROM data returns
            v2_q        <= v1_q;
            // t+3: index becomes palette address; transparent key drops validity
            pal_addr_q  <= rom.map_data;
            v3_q        <= v2_q & (rom.map_data != PAL_BITS'(TRANSP_IDX));
            // t+4: palette data returns
            v4_q        <= v3_q;
            // t+5: output
            pixel_q     <= v4_q ? rom.pal_data : 24'h0;
            pixel_vld_q <= v4_q;
        end
    end

    assign rom.map_addr = map_addr_q;
    assign rom.pal_addr = pal_addr_q;
    assign pixel_o      = pixel_q;
    assign pixel_vld_o  = pixel_vld_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// ---------------------------------------------------------------------------
// tb_sprite_renderer
//   Directed vectors for sprite_renderer. The stimulus process pushes the
//   hand-computed expected map address (checked one cycle later) and expected
//   pixel (checked five cycles later) into queues; a monitor on the falling
//   edge pops and compares. Map ROM content is idx = addr[3:0].
// ---------------------------------------------------------------------------
module tb_sprite_renderer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        blank, enable, mirror;
    logic [15:0] x, y;
    logic [7:0]  frame_sel;
    logic [23:0] pixel;
    logic        pixel_vld;

    always #5 clk = ~clk;

    sprite_renderer_if #(.MAP_AW(14), .PAL_BITS(4)) bus ();

    sprite_renderer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount_i    (hcount),
        .vcount_i    (vcount),
        .blank_i     (blank),
        .enable_i    (enable),
        .x_i         (x),
        .y_i         (y),
        .frame_sel_i (frame_sel),
        .mirror_i    (mirror),
        .rom         (bus),
        .pixel_o     (pixel),
        .pixel_vld_o (pixel_vld)
    );

    function automatic logic [23:0] pal(input logic [3:0] i);
        return {i, 4'h3, ~i, i, 4'h8, i};
    endfunction

    // External ROM models, one-cycle synchronous read
    always @(posedge clk) begin
        bus.map_data <= bus.map_addr[3:0];
        bus.pal_data <= pal(bus.pal_addr);
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned t;
        logic        vld;
        logic [23:0] pix;
        string       name;
    } pix_exp_t;

    typedef struct {
        int unsigned t;
        logic [13:0] addr;
        string       name;
    } addr_exp_t;

    pix_exp_t  pq[$];
    addr_exp_t aq[$];
    pix_exp_t  pe;
    addr_exp_t ae;
    int        n_vec = 0;
    int        n_err = 0;

    // Monitor: every output this cycle that was promised by the stimulus
    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].t + 5 <= cyc) begin
            pe = pq.pop_front();
            n_vec++;
            if (pe.t + 5 != cyc || pixel_vld !== pe.vld || pixel !== pe.pix) begin
                n_err++;
                $display("FAIL %s pixel: got vld=%0b pix=%06h (cyc %0d), want vld=%0b pix=%06h (cyc %0d)",
                         pe.name, pixel_vld, pixel, cyc, pe.vld, pe.pix, pe.t + 5);
            end else
                $display("ok   %s pixel vld=%0b pix=%06h", pe.name, pixel_vld, pixel);
        end
        while (aq.size() > 0 && aq[0].t + 1 <= cyc) begin
            ae = aq.pop_front();
            n_vec++;
            if (ae.t + 1 != cyc || bus.map_addr !== ae.addr) begin
                n_err++;
                $display("FAIL %s map_addr: got %0d (cyc %0d), want %0d (cyc %0d)",
                         ae.name, bus.map_addr, cyc, ae.addr, ae.t + 1);
            end else
                $display("ok   %s map_addr=%0d", ae.name, bus.map_addr);
        end
    end

    // One pixel position per cycle with its hand-computed map address and validity
    task automatic vec(input logic [10:0] h, input logic [9:0] v, input logic b,
                       input logic [13:0] ea, input logic ev, input string nm,
                       input bit push = 1'b1);
        @(posedge clk);
        #1;
        hcount = h;
        vcount = v;
        blank  = b;
        if (push) begin
            pq.push_back('{t: cyc, vld: ev, pix: (ev ? pal(ea[3:0]) : 24'h0), name: nm});
            aq.push_back('{t: cyc, addr: ea, name: nm});
        end
    endtask

    // Frame start cycle (0,0) during blanking: loads the shadow registers
    task automatic frame_start(input logic [15:0] fx, input logic [15:0] fy,
                               input logic [7:0] fs, input logic fm, input logic fe);
        @(posedge clk);
        #1;
        x = fx; y = fy; frame_sel = fs; mirror = fm; enable = fe;
        hcount = 11'd0;
        vcount = 10'd0;
        blank  = 1'b1;
        pq.push_back('{t: cyc, vld: 1'b0, pix: 24'h0, name: "frame_start"});
    endtask

    initial begin
        rst_n = 1'b0; blank = 1'b0; enable = 1'b1; mirror = 1'b0;
        x = 16'd0; y = 16'd0; frame_sel = 8'd0; hcount = 11'd0; vcount = 10'd0;

        // Reset held while hcount sweeps
        for (int i = 0; i < 8; i++) vec(11'(i * 3), 10'd0, 1'b0, 0, 1'b0, "reset");
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b1;

        // Nothing drawn before the first frame start
        vec(5, 5, 0, 0, 0, "pre_fs");

        // Basic placement, frame 0
        frame_start(100, 50, 0, 0, 1);
        vec(100, 50, 0, 0, 0, "tl_transp");
        vec(101, 50, 0, 1, 1, "tl_plus1");
        vec(99, 50, 0, 1, 0, "left_out");
        vec(163, 50, 0, 63, 1, "right_edge");
        vec(164, 50, 0, 63, 0, "right_out");
        vec(105, 51, 0, 69, 1, "row1");
        vec(110, 113, 0, 4042, 1, "bottom_row");
        vec(110, 114, 0, 4042, 0, "below_out");
        vec(110, 49, 0, 4042, 0, "above_out");
        vec(102, 50, 1, 4042, 0, "blank_in_box");

        // Mirror
        frame_start(100, 50, 0, 1, 1);
        vec(100, 50, 0, 63, 1, "mir_left");
        vec(163, 50, 0, 0, 0, "mir_right");
        vec(101, 50, 0, 62, 1, "mir_left1");
        vec(110, 51, 0, 117, 1, "mir_row1");

        // Frames and clamping
        frame_start(100, 50, 2, 0, 1);
        vec(100, 50, 0, 8192, 0, "frame2_tl");
        vec(103, 52, 0, 8323, 1, "frame2_mid");
        frame_start(100, 50, 9, 0, 1);
        vec(101, 50, 0, 8193, 1, "frame9_clamp");
        frame_start(100, 50, 3, 0, 1);
        vec(163, 113, 0, 12287, 1, "frame3_clamp_br");
        frame_start(100, 50, 1, 0, 1);
        vec(101, 50, 0, 4097, 1, "frame1");

        // Mid-frame position change has no effect until next frame start
        frame_start(100, 180, 0, 0, 1);
        vec(101, 200, 0, 1281, 1, "shadow_old");
        x = 16'd300;
        vec(300, 200, 0, 1281, 0, "shadow_new_out");
        vec(102, 200, 0, 1282, 1, "shadow_old2");
        frame_start(300, 180, 0, 0, 1);
        vec(301, 200, 0, 1281, 1, "shadow_next");
        vec(101, 200, 0, 1281, 0, "shadow_old_out");

        // Partly off-screen right, no wrap to column 0
        frame_start(1000, 0, 0, 0, 1);
        vec(1023, 0, 0, 23, 1, "offs_col1023");
        vec(1000, 5, 0, 320, 0, "offs_transp");
        vec(1001, 5, 0, 321, 1, "offs_col1001");
        vec(0, 3, 0, 321, 0, "offs_nowrap0");
        vec(39, 3, 0, 321, 0, "offs_nowrap39");
        vec(1010, 3, 1, 321, 0, "offs_blank");

        // Huge coordinates never come into range
        frame_start(2048, 0, 0, 0, 1);
        vec(2047, 0, 0, 321, 0, "x2048");
        vec(100, 0, 0, 321, 0, "x2048_b");
        frame_start(0, 40000, 0, 0, 1);
        vec(5, 5, 0, 321, 0, "y40000");

        // Disabled sprite
        frame_start(100, 50, 0, 0, 0);
        vec(101, 50, 0, 321, 0, "disabled");

        // Asynchronous reset while opaque pixels are being emitted
        frame_start(100, 50, 0, 0, 1);
        for (int i = 1; i <= 8; i++)
            vec(11'(100 + i), 50, 0, 14'(i), 1, "pre_rst", i <= 4);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pq.push_back('{t: cyc - 5, vld: 1'b0, pix: 24'h0, name: "async_rst"});
        aq.push_back('{t: cyc - 1, addr: 14'd0, name: "async_rst"});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        vec(101, 50, 0, 0, 0, "post_rst_hidden");
        frame_start(100, 50, 0, 0, 1);
        vec(101, 50, 0, 1, 1, "post_rst_redraw");

        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
